tail_mem_sequencer: RTL and testbench

- Multi-cycle controller for the single-port snake tail memory.
- On each game step it shifts the tail one slot:
  - tail[0] takes the previous head position.
  - tail[i] takes the old tail[i-1].
  - On growth, the tail is extended by one entry.
- Checks the new head against the old tail entries during the shift and reports collision.
- Arbitrates the memory port between itself and the display renderer. Sits between game_logic (step requests) and the tail RAM.

---
 rtl/tail_mem_sequencer.sv | 151 +++++++++++++++
 tb/tb_tail_mem_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tail_mem_sequencer.sv
// Snake tail shift sequencer: shifts the tail through a single-port RAM,
// checks the new head for collision and shares the port with the renderer.
module tail_mem_sequencer #(
  parameter int WORD_W   = 12,
  parameter int CNT_W    = 7,
  parameter int MEM_SIZE = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              grow,
  input  logic              clear,
  input  logic [WORD_W-1:0] head_prev,
  input  logic [WORD_W-1:0] head_new,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic [CNT_W-1:0]  disp_addr,
  output logic [CNT_W-1:0]  mem_addr,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              disp_grant,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic [CNT_W-1:0]  num_tails,
  output logic              full
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_APPEND,
    S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_num_tails;
  logic [WORD_W-1:0] r_carry;
  logic [WORD_W-1:0] r_head_new;
  logic              r_grow_eff;
  logic              r_collision;
  logic              w_full;
  logic              w_last;
  logic              w_hit;

  assign w_full = (r_num_tails == CNT_W'(MEM_SIZE));
  assign w_last = (r_idx == r_num_tails - CNT_W'(1));
  // The last old entry only matters if it survives the shift.
  assign w_hit  = (mem_rdata == r_head_new) &&
                  !(w_last && !r_grow_eff);

  assign collision = r_collision;
  assign num_tails = r_num_tails;
  assign full      = w_full;

  always_comb begin
    w_next     = r_state;
    mem_addr   = disp_addr;
    mem_we     = 1'b0;
    mem_wdata  = r_carry;
    disp_grant = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (r_num_tails != '0)
            w_next = S_RD;
          else if (grow && !w_full)
            w_next = S_APPEND;
          else
            w_next = S_FIN;
        end
      end
      S_RD: begin
        mem_addr   = r_idx;
        disp_grant = 1'b0;
        busy       = 1'b1;
        w_next     = S_WR;
      end
      S_WR: begin
        mem_addr   = r_idx;
        mem_we     = 1'b1;
        disp_grant = 1'b0;
        busy       = 1'b1;
        if (!w_last)
          w_next = S_RD;
        else if (r_grow_eff)
          w_next = S_APPEND;
        else
          w_next = S_FIN;
      end
      S_APPEND: begin
        mem_addr   = r_num_tails;
        mem_we     = 1'b1;
        disp_grant = 1'b0;
        busy       = 1'b1;
        w_next     = S_FIN;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (clear)
      w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_num_tails <= '0;
      r_carry     <= '0;
      r_head_new  <= '0;
      r_grow_eff  <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_state <= w_next;
      if (clear) begin
        r_num_tails <= '0;
        r_collision <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_carry     <= head_prev;
              r_head_new  <= head_new;
              r_grow_eff  <= grow & ~w_full;
              r_idx       <= '0;
              r_collision <= 1'b0;
            end
          end
          S_WR: begin
            r_carry <= mem_rdata;
            if (w_hit)
              r_collision <= 1'b1;
            if (!w_last)
              r_idx <= r_idx + CNT_W'(1);
          end
          S_APPEND: r_num_tails <= r_num_tails + CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tail_mem_sequencer.sv
// Randomized self-checking bench for tail_mem_sequencer against a
// queue-based model of the snake tail.
module tb_tail_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        grow = 1'b0;
  logic        clear = 1'b0;
  logic [11:0] head_prev = '0;
  logic [11:0] head_new = '0;
  logic [11:0] mem_rdata;
  logic [6:0]  disp_addr = 7'd9;
  logic [6:0]  mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic        disp_grant;
  logic        busy;
  logic        done;
  logic        collision;
  logic [6:0]  num_tails;
  logic        full;

  int total = 0;
  int passed = 0;

  logic [11:0] ram [0:127];
  logic [6:0]  wr_q [$];
  logic [11:0] mq [$];

  always #5 clk = ~clk;

  tail_mem_sequencer #(.WORD_W(12), .CNT_W(7), .MEM_SIZE(100)) dut (
    .clk(clk), .rst(rst), .start(start), .grow(grow), .clear(clear),
    .head_prev(head_prev), .head_new(head_new), .mem_rdata(mem_rdata),
    .disp_addr(disp_addr), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .disp_grant(disp_grant), .busy(busy),
    .done(done), .collision(collision), .num_tails(num_tails), .full(full)
  );

  // Registered-read, read-before-write RAM
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_q.push_back(mem_addr);
    end
  end

  // Reference: new tail = head_prev followed by the surviving old entries.
  function automatic void model_step(input logic [11:0] p,
                                     input logic [11:0] nw,
                                     input logic g,
                                     output int elat,
                                     output logic ecol,
                                     output int ewr);
    int n = mq.size();
    int gi = (g && n < 100) ? 1 : 0;
    int keep = gi ? n : (n > 0 ? n - 1 : 0);
    logic [11:0] nq [$];
    ecol = 1'b0;
    for (int i = 0; i < keep; i++)
      if (mq[i] == nw) ecol = 1'b1;
    elat = 2 * n + 1 + gi;
    ewr = n + gi;
    if (n + gi > 0) begin
      nq.push_back(p);
      for (int i = 0; i < keep; i++) nq.push_back(mq[i]);
    end
    mq = nq;
  endfunction

  function automatic int ram_mismatch();
    int c = 0;
    for (int i = 0; i < mq.size(); i++)
      if (ram[i] !== mq[i]) c++;
    return c;
  endfunction

  task automatic run_step(input logic [11:0] p, input logic [11:0] nw,
                          input logic g, output int lat, output logic col);
    wr_q.delete();
    @(negedge clk);
    head_prev = p; head_new = nw; grow = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    col = collision;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mq.delete();
  endtask

  task automatic test_shift(input string nm, input logic [11:0] p,
                            input logic [11:0] nw, input logic g);
    int elat, ewr, lat, bad, mm;
    logic ecol, col;
    model_step(p, nw, g, elat, ecol, ewr);
    run_step(p, nw, g, lat, col);
    bad = 0;
    foreach (wr_q[k]) if (int'(wr_q[k]) >= mq.size()) bad++;
    mm = ram_mismatch();
    total++;
    if (lat !== elat) $display("FAIL %s latency got %0d exp %0d", nm, lat, elat);
    else passed++;
    total++;
    if (col !== ecol) $display("FAIL %s collision got %b exp %b", nm, col, ecol);
    else passed++;
    total++;
    if (int'(num_tails) !== mq.size())
      $display("FAIL %s num_tails got %0d exp %0d", nm, num_tails, mq.size());
    else passed++;
    total++;
    if (full !== (mq.size() == 100)) $display("FAIL %s full got %b", nm, full);
    else passed++;
    total++;
    if (wr_q.size() !== ewr || bad !== 0)
      $display("FAIL %s writes got %0d (bad %0d) exp %0d", nm, wr_q.size(), bad, ewr);
    else passed++;
    total++;
    if (mm !== 0) $display("FAIL %s ram contents %0d wrong entries exp 0", nm, mm);
    else passed++;
  endtask

  task automatic preload();
    do_clear();
    test_shift("pre0", 12'h103, 12'hFFF, 1'b1);
    test_shift("pre1", 12'h102, 12'hFFF, 1'b1);
    test_shift("pre2", 12'h101, 12'hFFF, 1'b1);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 0 || done !== 0 || collision !== 0 || num_tails !== 0 ||
        mem_we !== 0 || disp_grant !== 1 || mem_addr !== 7'd9 || full !== 0)
      $display("FAIL reset outputs busy=%b done=%b col=%b n=%0d we=%b g=%b a=%0d",
               busy, done, collision, num_tails, mem_we, disp_grant, mem_addr);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_first_append();
    test_shift("append0", 12'h258, 12'h000, 1'b1);
  endtask

  task automatic test_preload_cases();
    preload();
    test_shift("shift3", 12'h100, 12'h0FF, 1'b0);
    preload();
    test_shift("hit_mid", 12'h100, 12'h102, 1'b0);
    preload();
    test_shift("last_nogrow", 12'h100, 12'h103, 1'b0);
    preload();
    test_shift("last_grow", 12'h100, 12'h103, 1'b1);
  endtask

  task automatic test_busy_start();
    int elat, ewr, lat;
    logic ecol;
    preload();
    model_step(12'h100, 12'h101, 1'b0, elat, ecol, ewr);
    wr_q.delete();
    @(negedge clk);
    head_prev = 12'h100; head_new = 12'h101; grow = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      if (lat == 3) begin
        start = 1'b1; head_prev = 12'h555; head_new = 12'h555; grow = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    total++;
    if (lat !== elat || collision !== ecol || int'(num_tails) !== mq.size())
      $display("FAIL busy_start lat=%0d col=%b n=%0d exp %0d %b %0d",
               lat, collision, num_tails, elat, ecol, mq.size());
    else passed++;
    total++;
    if (ram_mismatch() !== 0) $display("FAIL busy_start ram %0d wrong exp 0", ram_mismatch());
    else passed++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 0 || collision !== ecol)
      $display("FAIL fin_start busy=%b col=%b exp 0 %b", busy, collision, ecol);
    else passed++;
  endtask

  task automatic test_clear_mid();
    int dones = 0;
    preload();
    @(negedge clk);
    head_prev = 12'h200; head_new = 12'h102; grow = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mq.delete();
    total++;
    if (busy !== 0 || disp_grant !== 1 || num_tails !== 0 || collision !== 0 || done !== 0)
      $display("FAIL clear_mid busy=%b g=%b n=%0d col=%b done=%b",
               busy, disp_grant, num_tails, collision, done);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++;
    if (dones !== 0) $display("FAIL clear_nodone got %0d done pulses exp 0", dones);
    else passed++;
    @(negedge clk);
    clear = 1'b1; start = 1'b1; grow = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 0 || num_tails !== 0)
      $display("FAIL clear_start busy=%b n=%0d exp 0 0", busy, num_tails);
    else passed++;
  endtask

  task automatic test_disp_and_rst();
    preload();
    @(negedge clk);
    disp_addr = 7'd5;
    #1;
    total++;
    if (mem_addr !== 7'd5 || disp_grant !== 1)
      $display("FAIL disp_idle addr=%0d g=%b exp 5 1", mem_addr, disp_grant);
    else passed++;
    @(negedge clk);
    head_prev = 12'h300; head_new = 12'h0; grow = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (disp_grant !== 0 || mem_addr !== 7'd0 || mem_we !== 0 || busy !== 1)
      $display("FAIL disp_rd g=%b addr=%0d we=%b busy=%b", disp_grant, mem_addr, mem_we, busy);
    else passed++;
    @(negedge clk);
    total++;
    if (mem_we !== 1 || mem_wdata !== 12'h300 || disp_grant !== 0)
      $display("FAIL wr_phase we=%b wdata=%h g=%b exp 1 300 0", mem_we, mem_wdata, disp_grant);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 0 || mem_we !== 0 || disp_grant !== 1 || mem_addr !== 7'd5 ||
        num_tails !== 0 || done !== 0 || collision !== 0)
      $display("FAIL rst_wr busy=%b we=%b g=%b a=%0d n=%0d", busy, mem_we,
               disp_grant, mem_addr, num_tails);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
  endtask

  task automatic test_random();
    do_clear();
    for (int i = 0; i < 60; i++)
      test_shift("rand", 12'($urandom_range(0, 7)), 12'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)));
  endtask

  task automatic test_full();
    do_clear();
    for (int i = 0; i < 100; i++)
      test_shift("fill", 12'($urandom_range(0, 4095)), 12'hFFF, 1'b1);
    test_shift("full_grow", 12'h7A5, 12'hFFF, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = '0;
    test_reset();
    test_first_append();
    test_preload_cases();
    test_busy_start();
    test_clear_mid();
    test_disp_and_rst();
    test_random();
    test_full();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
